// File: rtl/udma_fifo_rr_arbiter.sv
// Round-robin arbiter sharing one uDMA FIFO source port among N_REQ stream producers.
// Define UDMA_ARB_BURST_EN to hold each grant for up to MAX_BURST beats; otherwise grants rotate every beat.
module udma_fifo_rr_arbiter #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 4,
  parameter int ID_WIDTH   = $clog2(N_REQ)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        cfg_en_i,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data_i,
  input  logic [N_REQ-1:0]            req_valid_i,
  output logic [N_REQ-1:0]            req_ready_o,
  output logic [DATA_WIDTH-1:0]       out_data_o,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [ID_WIDTH-1:0]         out_id_o,
  output logic                        busy_o
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
`ifdef UDMA_ARB_BURST_EN
  localparam int BURST_LIMIT = MAX_BURST;
`else
  localparam int BURST_LIMIT = 1;
`endif
  localparam logic [CNT_W-1:0]    LIMIT_C = CNT_W'(BURST_LIMIT);
  localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(N_REQ - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t              state_reg, state_next;
  logic [ID_WIDTH-1:0] grant_reg, grant_next;
  logic [ID_WIDTH-1:0] rr_ptr_reg, rr_ptr_next;
  logic [CNT_W-1:0]    beat_cnt_reg, beat_cnt_next;
  logic [ID_WIDTH-1:0] sel_idx;
  logic                sel_found;
  logic                grant_valid;
  int                  off;
  int                  best_off;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg    <= IDLE;
      grant_reg    <= '0;
      rr_ptr_reg   <= '0;
      beat_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      grant_reg    <= grant_next;
      rr_ptr_reg   <= rr_ptr_next;
      beat_cnt_reg <= beat_cnt_next;
    end
  end

  // Pick the valid requester with the smallest distance above rr_ptr (wrapping).
  always_comb begin
    sel_idx  = '0;
    off      = 0;
    best_off = N_REQ;
    for (int k = 0; k < N_REQ; k++) begin
      off = (k + N_REQ - int'(rr_ptr_reg)) % N_REQ;
      if (req_valid_i[k] && (off < best_off)) begin
        best_off = off;
        sel_idx  = ID_WIDTH'(k);
      end
    end
    sel_found = (best_off < N_REQ);
  end

  assign grant_valid = req_valid_i[grant_reg];

  always_comb begin
    state_next    = state_reg;
    grant_next    = grant_reg;
    rr_ptr_next   = rr_ptr_reg;
    beat_cnt_next = beat_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (cfg_en_i && sel_found) begin
          state_next    = GRANT;
          grant_next    = sel_idx;
          beat_cnt_next = '0;
        end
      end
      GRANT: begin
        // An idle release and a final-beat handshake both hand the pointer to the next index.
        if (!grant_valid || (out_ready_i && ((beat_cnt_reg + 1'b1) == LIMIT_C))) begin
          state_next    = IDLE;
          beat_cnt_next = '0;
          rr_ptr_next   = (grant_reg == LAST_ID) ? '0 : grant_reg + 1'b1;
        end else if (out_ready_i) begin
          beat_cnt_next = beat_cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    out_valid_o = 1'b0;
    out_data_o  = '0;
    out_id_o    = '0;
    if (state_reg == GRANT) begin
      out_valid_o = grant_valid;
      out_data_o  = req_data_i[int'(grant_reg)*DATA_WIDTH +: DATA_WIDTH];
      out_id_o    = grant_reg;
    end
  end

  assign busy_o = (state_reg == GRANT);

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
    assign req_ready_o[gi] = (state_reg == GRANT) && (grant_reg == ID_WIDTH'(gi)) && out_ready_i;
  end

endmodule

// File: doc/udma_fifo_rr_arbiter.md
# udma_fifo_rr_arbiter

Round-robin arbiter that lets N_REQ uDMA stream producers share the source (write) port of one dual-clock uDMA FIFO. It sits entirely in the FIFO's source clock domain and grants one requester at a time, passing its data and valid/ready through to the FIFO. The granted channel index travels beside each beat. With burst mode compiled in, a grant is held for up to MAX_BURST beats to cut arbitration overhead.

## Interface
- N_REQ, 4: number of requesters, 2..16.
- DATA_WIDTH, 32: beat width; must equal the downstream FIFO DATA_WIDTH.
- MAX_BURST, 4: maximum beats per grant in burst mode, 1..256.
- ID_WIDTH, $clog2(N_REQ): derived width of the channel index; do not override.
- clk_i  in  1  source-domain clock; connect to the FIFO src_clk_i.
- rst_i  in  1  reset; synchronous, active-high.
- cfg_en_i  in  1  arbiter enable; when low, no new grant is issued and an active grant runs to completion.
- req_data_i  in  N_REQ*DATA_WIDTH  requester data; requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- req_valid_i  in  N_REQ  per-requester valid.
- req_ready_o  out  N_REQ  per-requester ready; at most one bit is high in any cycle.
- out_data_o  out  DATA_WIDTH  data of the granted requester, to FIFO src_data_i.
- out_valid_o  out  1  to FIFO src_valid_i.
- out_ready_i  in  1  from FIFO src_ready_o.
- out_id_o  out  ID_WIDTH  index of the granted requester.
- busy_o  out  1  high while a grant is active.

## Operation
- Registered state: fsm (IDLE, GRANT), grant index, rr_ptr, beat_cnt (width $clog2(MAX_BURST+1)).
- IDLE:
  - If cfg_en_i=1 and any req_valid_i bit is high, select the first valid index scanning upward from rr_ptr and wrapping modulo N_REQ.
  - Register that index into grant, clear beat_cnt, go to GRANT.
  - Otherwise stay in IDLE.
- GRANT:
  - out_valid_o = req_valid_i[grant].
  - req_ready_o[grant] = out_ready_i; all other ready bits are 0.
  - out_data_o = req_data_i slice [grant].
  - out_id_o = grant.
  - A handshake is out_valid_o & out_ready_i. Each handshake increments beat_cnt.
- GRANT exits to IDLE, with rr_ptr set to (grant+1) mod N_REQ, when either of these holds:
  - A handshake occurs and beat_cnt+1 equals the burst limit.
  - req_valid_i[grant]=0. This is an idle release: no beat transfers in that cycle.
- Burst limit: MAX_BURST when burst mode is compiled in, otherwise 1.
- In IDLE: out_valid_o=0, req_ready_o=0, out_data_o=0, out_id_o=0.
- busy_o = (fsm==GRANT).
- cfg_en_i only gates the IDLE→GRANT transition. It never truncates an active grant.
- A requester dropping valid without a handshake is permitted and causes an idle release. No data is lost.

## Timing
- Reset state:
  - fsm=IDLE, grant=0, rr_ptr=0, beat_cnt=0.
  - All outputs 0 in the cycle after rst_i is sampled high.
- Reset mid-burst: the grant is abandoned immediately. The FIFO sees no further valid beats.
- Latency and throughput:
  - Arbitration latency is 1 cycle: a request seen in IDLE at edge n gives out_valid_o high from cycle n+1.
  - Every grant transition costs one bubble cycle in IDLE.
  - Data path is combinational from request to output (zero latency).
- Backpressure: when out_ready_i=0 in GRANT, state holds and beat_cnt does not change. The grant is not lost to a stalled FIFO.
- Fairness: a requester waits at most (N_REQ-1) grants of length ≤ burst limit, plus one bubble cycle per grant.
- Simultaneous events:
  - Handshake on the final burst beat together with other requesters valid: release at that edge, next grant one cycle later.
  - rr_ptr wraps from N_REQ-1 to 0.

## Configuration
- UDMA_ARB_BURST_EN defined: the burst limit is MAX_BURST, and the grant is held across consecutive beats as described.
- UDMA_ARB_BURST_EN undefined:
  - The burst limit is fixed at 1. The grant rotates after every beat and MAX_BURST is ignored.
  - beat_cnt logic may be removed by synthesis.

## Test plan
- Reset with all req_valid_i=1 → all outputs 0. After rst_i falls: grant 0 in cycle 1, out_id_o=0.
- N_REQ=4, MAX_BURST=4, burst on, all four requesters streaming, out_ready_i=1 → ids 0,0,0,0,bubble,1,1,1,1,bubble,2…; with burst off → ids 0,bubble,1,bubble,2,bubble,3,bubble,0.
- Requester 2 granted, out_ready_i held low for 5 cycles → out_valid_o stays 1, req_ready_o=0, beat_cnt unchanged. Burst resumes after ready rises and completes at 4 beats.
- Requester 1 drops valid after 2 of 4 beats → release with no transfer, rr_ptr=2. Requester 1 re-asserts and is served only after requesters 2 and 3 (if valid).
- cfg_en_i=0 during an active grant of requester 3 → burst completes, then fsm stays IDLE, busy_o=0. When cfg_en_i returns to 1, requester 0 is granted next (wrap).
- rst_i asserted mid-burst after 2 beats → next cycle out_valid_o=0, busy_o=0, rr_ptr=0. The scoreboard sees no duplicated or corrupted beats in the FIFO.
